coin_acceptor: RTL and testbench

Front-end stage of the coffee vending path. Takes the raw, bouncy 5c and 10c slot sensors and synchronises and debounces them. Converts each physical insertion into exactly one single-cycle coin code on `coins`, the 2-bit coin input of the vending FSM directly downstream. Also flags a jammed slot.

---
 rtl/coin_pkg.sv | 28 ++
 rtl/coin_channel.sv | 135 +++++++++++++
 rtl/coin_acceptor.sv | 103 ++++++++++
 tb/tb_coin_acceptor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes, channel state encoding and the saturating tally adder
// for the coin acceptor front end.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_QUAL    = 3'd2,
        ST_HELD    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_JAM     = 3'd5
    } chan_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {12'd0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/coin_channel.sv
// One coin slot: synchroniser, debounce/jam counter and the channel FSM.
// Emits a single-cycle credit event per physical insertion and flags a jam.
module coin_channel
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic sense,
    output logic ev,
    output logic in_jam
);

    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    chan_state_t            state_r;
    chan_state_t            state_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_s;
    logic                   ev_s;

    // Synchroniser shift register for the asynchronous slot sensor
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sense};
        end
    end

    assign s_s = sync_r[SYNC_STAGES-1];

    // Channel state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ARM;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter update and credit event decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ev_s    = 1'b0;
        case (state_r)
            ST_ARM: begin
                // A coin already in the slot at reset must leave before we arm
                if (cnt_r == DEB_C) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (s_s) begin
                    cnt_s = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (s_s) begin
                    state_s = ST_QUAL;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_QUAL: begin
                if (cnt_r == DEB_C) begin
                    ev_s    = 1'b1;
                    state_s = ST_HELD;
                    cnt_s   = CNT_ZERO;
                end else if (!s_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                // The JAM_CYCLES-th high sample after crediting lands straight in JAM
                if (s_s) begin
                    if (cnt_r == JAM_LAST) begin
                        state_s = ST_JAM;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_RELEASE;
                    cnt_s   = CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (cnt_r == DEB_C) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (s_s) begin
                    state_s = ST_HELD;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_JAM: begin
                if (cnt_r == DEB_C) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (s_s) begin
                    cnt_s = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_ARM;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    assign ev     = ev_s;
    assign in_jam = (state_r == ST_JAM);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two debounced slot channels, credit arbiter and jam flag.
// Optional running tally of credited value enabled by COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sense_5,
    input  logic        sense_10,
    output logic [1:0]  coins,
`ifdef COIN_ACCEPTOR_TALLY_EN
    output logic [15:0] tally,
`endif
    output logic        jam
);

    logic       ev5_s;
    logic       ev10_s;
    logic       jam5_s;
    logic       jam10_s;
    logic [1:0] coins_r;
    logic [1:0] coins_s;
    logic       held10_r;
    logic       held10_s;

    coin_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_ch5 (
        .clk    (clk),
        .reset  (reset),
        .sense  (sense_5),
        .ev     (ev5_s),
        .in_jam (jam5_s)
    );

    coin_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_ch10 (
        .clk    (clk),
        .reset  (reset),
        .sense  (sense_10),
        .ev     (ev10_s),
        .in_jam (jam10_s)
    );

    // Arbiter: a deferred 10c wins, then 5c (deferring a coincident 10c), then 10c
    always_comb begin
        coins_s  = COIN_NONE;
        held10_s = 1'b0;
        if (held10_r) begin
            coins_s = COIN_10;
        end else if (ev5_s) begin
            coins_s  = COIN_5;
            held10_s = ev10_s;
        end else if (ev10_s) begin
            coins_s = COIN_10;
        end else begin
            coins_s = COIN_NONE;
        end
    end

    // Coin code and deferred-10c registers
    always_ff @(posedge clk) begin
        if (reset) begin
            coins_r  <= COIN_NONE;
            held10_r <= 1'b0;
        end else begin
            coins_r  <= coins_s;
            held10_r <= held10_s;
        end
    end

    assign coins = coins_r;
    assign jam   = jam5_s | jam10_s;

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [15:0] tally_r;

    // Running credit total, follows the registered coin code by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tally_r <= 16'd0;
        end else if (coins_r == COIN_5) begin
            tally_r <= sat_add16(tally_r, 5'd5);
        end else if (coins_r == COIN_10) begin
            tally_r <= sat_add16(tally_r, 5'd10);
        end else begin
            tally_r <= tally_r;
        end
    end

    assign tally = tally_r;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected coin pulses are queued at stimulus
// time with their due cycle and compared every cycle; jam checked against a window.
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int JAM_CYCLES      = 32;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       sense_5;
    logic       sense_10;
    logic [1:0] coins;
    logic       jam;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [15:0] tally;
`endif

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   jam_on   = 0;
    int   jam_off  = 0;
    bit   mon_en   = 1'b0;

    coin_acceptor #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sense_5  (sense_5),
        .sense_10 (sense_10),
        .coins    (coins),
`ifdef COIN_ACCEPTOR_TALLY_EN
        .tally    (tally),
`endif
        .jam      (jam)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Per-cycle scoreboard compare of coins and jam, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                check_val("coin_pulse", 32'(coins), 32'(sb_q[0].code));
                void'(sb_q.pop_front());
            end else begin
                check_val("coin_idle", 32'(coins), 32'(COIN_NONE));
            end
            check_val("jam", 32'(jam), 32'(cyc >= jam_on && cyc < jam_off));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive pins high for hi samples then low for lo; queue expected codes at +LAT/+LAT+1
    task automatic pulse(input logic v5, input logic v10, input int hi, input int lo,
                         input logic [1:0] first, input logic [1:0] second);
        exp_t e;
        int   base;
        base = cyc + 1;
        if (first != COIN_NONE) begin
            e.cyc = base + LAT; e.code = first; sb_q.push_back(e);
        end
        if (second != COIN_NONE) begin
            e.cyc = base + LAT + 1; e.code = second; sb_q.push_back(e);
        end
        sense_5  = v5;
        sense_10 = v10;
        repeat (hi) @(negedge clk);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_coins", 32'(coins), 32'(COIN_NONE));
        check_val("reset_jam", 32'(jam), 32'd0);
`ifdef COIN_ACCEPTOR_TALLY_EN
        check_val("reset_tally", 32'(tally), 32'd0);
`endif
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(10);

        // single 5c insertion
        pulse(1'b1, 1'b0, 20, 20, COIN_5, COIN_NONE);

        // short 10c glitches never credit
        repeat (5) pulse(1'b0, 1'b1, 3, 5, COIN_NONE, COIN_NONE);
        idle(10);

        // simultaneous insertion: 5c then 10c on the next cycle
        pulse(1'b1, 1'b1, 15, 20, COIN_5, COIN_10);

        // 10c held past the jam limit
        jam_on  = cyc + 1 + LAT + JAM_CYCLES;
        jam_off = cyc + 1 + 60 + LAT;
        pulse(1'b0, 1'b1, 60, 20, COIN_10, COIN_NONE);

        // reset while a 5c is qualifying: no credit until removed and re-inserted
        base    = cyc + 1;
        sense_5 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        sense_5 = 1'b0;
        check_val("reset_mid_cycle", 32'(cyc - base), 32'd19);
        repeat (10) @(negedge clk);
        pulse(1'b1, 1'b0, 20, 20, COIN_5, COIN_NONE);

`ifdef COIN_ACCEPTOR_TALLY_EN
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(10);
        pulse(1'b1, 1'b0, 10, 15, COIN_5, COIN_NONE);
        pulse(1'b0, 1'b1, 10, 15, COIN_10, COIN_NONE);
        pulse(1'b0, 1'b1, 10, 15, COIN_10, COIN_NONE);
        idle(3);
        check_val("tally_25", 32'(tally), 32'd25);
        force dut.tally_r = 16'd65530;
        @(negedge clk);
        release dut.tally_r;
        @(negedge clk);
        check_val("tally_preload", 32'(tally), 32'd65530);
        pulse(1'b0, 1'b1, 10, 15, COIN_10, COIN_NONE);
        check_val("tally_sat", 32'(tally), 32'd65535);
`endif

        idle(5);
        mon_en = 1'b0;
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
